// File: rtl/bsg_serial_in_parallel_out_dynamic_pkg.sv
// Shared helpers for the dynamic serial-in, parallel-out assembler.
// Holds only width arithmetic. Each block keeps its own data types.
package bsg_serial_in_parallel_out_dynamic_pkg;

    // Minimum width of 1 keeps 1-entry structures free of zero-width vectors.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_array_reverse.sv
// Reverses the element order of a packed array of els_p words,
// each width_p bits wide.
module bsg_array_reverse #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic [width_p*els_p-1:0] i,
    output logic [width_p*els_p-1:0] o
);

    for (genvar k = 0; k < els_p; k++) begin : g_rev
        assign o[k*width_p +: width_p] = i[(els_p-1-k)*width_p +: width_p];
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO. ready_param_o comes from registered occupancy
// only, so callers can gate pushes without creating a combinational path.
module bsg_fifo_1r1w_small
    import bsg_serial_in_parallel_out_dynamic_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_param_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                full;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full          = (count_r == cnt_w_lp'(els_p));
    assign ready_param_o = ~full;
    assign v_o           = (count_r != '0);
    assign data_o        = mem_r[rd_ptr_r];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (v_i)
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (yumi_i)
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({v_i, yumi_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is deliberately left unreset; v_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (v_i)
            mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_serial_in_parallel_out_dynamic.sv
// Assembles variable-length packets of serial words into a max_els_p-wide
// array. Length arrives with the first word; unused slots are zero-filled.
module bsg_serial_in_parallel_out_dynamic
    import bsg_serial_in_parallel_out_dynamic_pkg::*;
#(
    parameter int  width_p       = 8,
    parameter int  max_els_p     = 4,
    parameter int  fifo_els_p    = 2,
    parameter bit  hi_to_lo_p    = 1'b0,
    localparam int lg_max_els_lp = safe_clog2(max_els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    output logic                         ready_and_o,
    input  logic [width_p-1:0]           data_i,
    input  logic [lg_max_els_lp-1:0]     len_i,
    output logic [max_els_p*width_p-1:0] data_o,
    output logic [lg_max_els_lp-1:0]     len_o,
    output logic                         v_o,
    input  logic                         yumi_i
);

    localparam int store_els_lp  = (max_els_p > 1) ? max_els_p - 1 : 1;
    localparam int pkt_width_lp  = max_els_p * width_p;
    localparam int fifo_width_lp = pkt_width_lp + lg_max_els_lp;

    logic [lg_max_els_lp-1:0] count_r, count_n;
    logic [lg_max_els_lp-1:0] len_r, len_n;
    logic [lg_max_els_lp-1:0] pkt_len;
    logic [width_p-1:0]       slot_r [store_els_lp];

    logic                     fifo_ready;
    logic                     first, last, mid_r;
    logic                     accept, push;
    logic [pkt_width_lp-1:0]  pkt_data;
    logic [pkt_width_lp-1:0]  fifo_pkt;
    logic [fifo_width_lp-1:0] fifo_data;

    assign first   = (count_r == '0);
    assign pkt_len = first ? len_i : len_r;
    assign last    = (count_r == pkt_len);

    // Middle words never reach the FIFO, so they bypass the full flag.
    // Only registered state feeds ready_and_o.
    assign mid_r       = ~first & (count_r != len_r);
    assign ready_and_o = fifo_ready | mid_r;

    assign accept = v_i & ready_and_o;
    assign push   = accept & last;

    always_comb begin
        count_n = count_r;
        len_n   = len_r;
        if (accept) begin
            if (first)
                len_n = len_i;
            if (last)
                count_n = '0;
            else
                count_n = count_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
            len_r   <= '0;
        end else begin
            count_r <= count_n;
            len_r   <= len_n;
        end
    end

    // The final word of a packet goes straight into the push, never into storage.
    always_ff @(posedge clk_i) begin
        if (accept && !last)
            slot_r[count_r] <= data_i;
    end

    for (genvar i = 0; i < max_els_p; i++) begin : g_pkt
        logic [width_p-1:0] stored;
        if (i < max_els_p - 1) begin : g_stored
            assign stored = slot_r[i];
        end else begin : g_none
            assign stored = '0;
        end
        assign pkt_data[i*width_p +: width_p] =
            (i > int'(pkt_len))   ? '0     :
            (i == int'(count_r))  ? data_i : stored;
    end

    bsg_fifo_1r1w_small #(
        .width_p (fifo_width_lp),
        .els_p   (fifo_els_p)
    ) pkt_fifo (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (push),
        .ready_param_o (fifo_ready),
        .data_i        ({pkt_len, pkt_data}),
        .v_o           (v_o),
        .data_o        (fifo_data),
        .yumi_i        (yumi_i)
    );

    assign {len_o, fifo_pkt} = fifo_data;

    if (hi_to_lo_p) begin : g_reverse
        bsg_array_reverse #(
            .width_p (width_p),
            .els_p   (max_els_p)
        ) out_rev (
            .i (fifo_pkt),
            .o (data_o)
        );
    end else begin : g_forward
        assign data_o = fifo_pkt;
    end

    a_yumi_needs_valid : assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
    ) else $error("yumi_i asserted while v_o is low");

    if ((max_els_p & (max_els_p - 1)) != 0) begin : g_len_chk
        a_len_in_range : assert property (
            @(posedge clk_i) disable iff (reset_i)
            (accept && first) |-> (int'(len_i) < max_els_p)
        ) else $error("len_i exceeds max_els_p-1");
    end

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_dynamic.sv
// Scoreboard bench: the stimulus queues expected packets, and negedge
// monitors compare each popped packet on a forward and a reversed instance.
module tb_bsg_serial_in_parallel_out_dynamic;

    logic        clk = 1'b0;
    logic        reset;
    logic        v_i;
    logic [7:0]  data_i;
    logic [1:0]  len_i;
    logic        yumi_en;

    logic        ready, ready_rev;
    logic [31:0] data_o, data_o_rev;
    logic [1:0]  len_o, len_o_rev;
    logic        v_o, v_o_rev;
    logic        yumi, yumi_rev;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_d_q  [$];
    logic [1:0]  exp_l_q  [$];
    logic [31:0] exp_r_q  [$];
    logic [1:0]  exp_lr_q [$];

    always #5 clk = ~clk;

    assign yumi     = yumi_en & v_o;
    assign yumi_rev = yumi_en & v_o_rev;

    bsg_serial_in_parallel_out_dynamic #(
        .width_p(8), .max_els_p(4), .fifo_els_p(2), .hi_to_lo_p(1'b0)
    ) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_and_o(ready),
        .data_i(data_i), .len_i(len_i), .data_o(data_o), .len_o(len_o),
        .v_o(v_o), .yumi_i(yumi)
    );

    bsg_serial_in_parallel_out_dynamic #(
        .width_p(8), .max_els_p(4), .fifo_els_p(2), .hi_to_lo_p(1'b1)
    ) dut_rev (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_and_o(ready_rev),
        .data_i(data_i), .len_i(len_i), .data_o(data_o_rev), .len_o(len_o_rev),
        .v_o(v_o_rev), .yumi_i(yumi_rev)
    );

    function automatic logic [31:0] zfill(input logic [31:0] raw, input int len);
        for (int i = 0; i < 4; i++)
            if (i > len) raw[i*8 +: 8] = 8'h00;
        return raw;
    endfunction

    function automatic logic [31:0] rev(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] d;
        logic [1:0]  l;
        if (v_o && yumi) begin
            if (exp_d_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL main_unexpected_pop actual=%0h required=none", data_o);
            end else begin
                d = exp_d_q.pop_front();
                l = exp_l_q.pop_front();
                check("main_data", data_o, d);
                check("main_len", 32'(len_o), 32'(l));
            end
        end
        if (v_o_rev && yumi_rev) begin
            if (exp_r_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rev_unexpected_pop actual=%0h required=none", data_o_rev);
            end else begin
                d = exp_r_q.pop_front();
                l = exp_lr_q.pop_front();
                check("rev_data", data_o_rev, d);
                check("rev_len", 32'(len_o_rev), 32'(l));
            end
        end
    end

    // Presents one word and returns #1 after the edge that accepts it.
    task automatic send_word(input logic [7:0] d, input logic [1:0] l, output int stalls);
        v_i    = 1'b1;
        data_i = d;
        len_i  = l;
        stalls = 0;
        while (!ready && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=stalled required=accepted data=%0h", d);
        end
        @(posedge clk); #1;
    endtask

    // Non-first words carry an inverted len_i, which the design must ignore.
    task automatic send_pkt(input int len, input logic [31:0] raw, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i <= len; i++) begin
            send_word(raw[i*8 +: 8], (i == 0) ? 2'(len) : ~2'(len), s);
            stalls += s;
        end
        exp_d_q.push_back(zfill(raw, len));
        exp_l_q.push_back(2'(len));
        exp_r_q.push_back(rev(zfill(raw, len)));
        exp_lr_q.push_back(2'(len));
    endtask

    task automatic drain();
        int n = 0;
        v_i     = 1'b0;
        yumi_en = 1'b1;
        while ((exp_d_q.size() != 0 || exp_r_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_d_q.size() + exp_r_q.size()), 32'd0);
        check("drain_v_o", 32'(v_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, total;
        reset   = 1'b0;
        v_i     = 1'b0;
        data_i  = 8'h00;
        len_i   = 2'd0;
        yumi_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset_v_o", 32'(v_o), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset mid-packet with one packet already buffered.
        send_pkt(0, 32'h0000_0077, s);
        v_i = 1'b0;
        check("pre_reset_v_o", 32'(v_o), 32'd1);
        send_word(8'hE0, 2'd3, s);
        send_word(8'hE1, 2'd0, s);
        #3 reset = 1'b1;
        v_i = 1'b0;
        #1;
        check("mid_reset_v_o", 32'(v_o), 32'd0);
        check("mid_reset_v_o_rev", 32'(v_o_rev), 32'd0);
        check("mid_reset_ready", 32'(ready), 32'd1);
        exp_d_q.delete(); exp_l_q.delete(); exp_r_q.delete(); exp_lr_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        send_pkt(3, 32'hA3A2_A1A0, s);
        v_i = 1'b0;
        check("post_reset_latency", 32'(v_o), 32'd1);
        drain();

        // Full packet with consumer always ready.
        yumi_en = 1'b1;
        send_pkt(3, 32'h1312_1110, s);
        v_i = 1'b0;
        check("full_latency", 32'(v_o), 32'd1);
        drain();

        // Short packet: upper garbage must be zero-filled.
        send_pkt(1, 32'hDEAD_2211, s);
        v_i = 1'b0;
        drain();

        // Stream of single-word packets at full rate.
        yumi_en = 1'b1;
        total   = 0;
        for (int k = 0; k < 8; k++) begin
            send_pkt(0, {24'hC0FFEE, 8'(k)}, s);
            total += s;
            check("stream_v_o", 32'(v_o), 32'd1);
        end
        v_i = 1'b0;
        check("stream_stalls", 32'(total), 32'd0);
        drain();

        // Backpressure: two packets fill the FIFO, the third stalls on its first word.
        yumi_en = 1'b0;
        send_pkt(1, 32'h0000_3231, s);
        send_pkt(1, 32'h0000_4241, s);
        v_i    = 1'b1;
        data_i = 8'h51;
        len_i  = 2'd1;
        check("bp_ready_full", 32'(ready), 32'd0);
        check("bp_ready_full_rev", 32'(ready_rev), 32'd0);
        check("bp_v_o", 32'(v_o), 32'd1);
        yumi_en = 1'b1;
        @(posedge clk); #1;
        yumi_en = 1'b0;
        check("bp_ready_after_pop", 32'(ready), 32'd1);
        @(posedge clk); #1;
        send_word(8'h52, 2'd0, s);
        check("bp_last_no_stall", 32'(s), 32'd0);
        v_i = 1'b0;
        exp_d_q.push_back(32'h0000_5251);
        exp_l_q.push_back(2'd1);
        exp_r_q.push_back(32'h5152_0000);
        exp_lr_q.push_back(2'd1);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
